lite_timer_pwm: RTL and testbench



---
 rtl/lite_timer_pwm.sv | 181 ++++++++++++++++++
 tb/tb_lite_timer_pwm.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lite_timer_pwm.sv
// Register-mapped down-counting timer with level interrupt and four LED PWM channels, on a Xillybus Lite style bus.
// Latency: read data appears 1 cycle after user_rden; user_irq follows EXPIRED by 1 cycle; led_pwm is registered.
// Backpressure: none; every bus access completes in a single cycle.
module lite_timer_pwm #(
  parameter int PRESCALE_W = 16,
  parameter int PWM_W      = 8
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic [31:0] user_addr,
  input  logic        user_wren,
  input  logic [3:0]  user_wstrb,
  input  logic [31:0] user_wr_data,
  input  logic        user_rden,
  output logic [31:0] user_rd_data,
  output logic        user_irq,
  output logic [3:0]  led_pwm
);

  localparam logic [31:0] ID_VALUE = 32'h54504D01;

  logic [2:0]            ctrl;        // [0] EN, [1] AUTO, [2] IRQEN
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pcnt;
  logic [31:0]           reload;
  logic [31:0]           count;
  logic                  expired;
  logic [PWM_W-1:0]      pwm_period;
  logic [PWM_W-1:0]      pwm_cnt;
  logic [4*PWM_W-1:0]    duty;        // lane i at [i*PWM_W +: PWM_W]

  logic [4:0]  idx;
  logic [31:0] wmask;
  logic [31:0] rd_mux;
  logic        tick;
  logic        expire;
  logic        wr_ctrl;
  logic        wr_count;
  logic        clr_status;

  // Only address bits [6:2] select a word; the rest are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{user_addr[31:7], user_addr[1:0]};

  assign idx   = user_addr[6:2];
  assign wmask = {{8{user_wstrb[3]}}, {8{user_wstrb[2]}}, {8{user_wstrb[1]}}, {8{user_wstrb[0]}}};

  // CTRL only has bits in lane 0, so only a lane-0 write counts as a CTRL write.
  assign wr_ctrl    = user_wren && (idx == 5'd0) && user_wstrb[0];
  assign wr_count   = user_wren && (idx == 5'd3) && (|user_wstrb);
  assign clr_status = user_wren && (idx == 5'd4) && user_wstrb[0] && user_wr_data[0];

  assign tick   = ctrl[0] && (pcnt == prescale);
  assign expire = tick && (count <= 32'd1);

  // Prescaler: free-runs while enabled, parked at zero while disabled.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      pcnt <= '0;
    end else if (!ctrl[0] || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Control and count: a software write takes priority over the tick's update of the same register.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      ctrl  <= '0;
      count <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl <= user_wr_data[2:0];
      end else if (expire && !ctrl[1]) begin
        ctrl[0] <= 1'b0;
      end

      if (wr_count) begin
        count <= (count & ~wmask) | (user_wr_data & wmask);
      end else if (tick) begin
        if (count > 32'd1) begin
          count <= count - 32'd1;
        end else if (ctrl[1]) begin
          count <= reload;
        end else begin
          count <= '0;
        end
      end
    end
  end

  // Plain configuration registers with byte-lane write enables.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      prescale   <= '0;
      reload     <= '0;
      pwm_period <= '0;
      duty       <= '0;
    end else if (user_wren) begin
      case (idx)
        5'd1: prescale <= (prescale & ~wmask[PRESCALE_W-1:0]) |
                          (user_wr_data[PRESCALE_W-1:0] & wmask[PRESCALE_W-1:0]);
        5'd2: reload <= (reload & ~wmask) | (user_wr_data & wmask);
        5'd5: pwm_period <= (pwm_period & ~wmask[PWM_W-1:0]) |
                            (user_wr_data[PWM_W-1:0] & wmask[PWM_W-1:0]);
        5'd6: duty <= (duty & ~wmask[4*PWM_W-1:0]) |
                      (user_wr_data[4*PWM_W-1:0] & wmask[4*PWM_W-1:0]);
        default: ;
      endcase
    end
  end

  // Expiry flag: hardware set beats a simultaneous write-1-to-clear.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      expired <= 1'b0;
    end else if (expire) begin
      expired <= 1'b1;
    end else if (clr_status) begin
      expired <= 1'b0;
    end
  end

  // Interrupt is the masked flag, registered.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      user_irq <= 1'b0;
    end else begin
      user_irq <= expired & ctrl[2];
    end
  end

  // Read mux reflects register contents before any same-cycle write lands.
  always_comb begin
    rd_mux = '0;
    case (idx)
      5'd0: rd_mux = {29'd0, ctrl};
      5'd1: rd_mux = 32'(prescale);
      5'd2: rd_mux = reload;
      5'd3: rd_mux = count;
      5'd4: rd_mux = {31'd0, expired};
      5'd5: rd_mux = 32'(pwm_period);
      5'd6: rd_mux = 32'(duty);
      5'd7: rd_mux = ID_VALUE;
      default: rd_mux = '0;
    endcase
  end

  // Read data register: captures on a read request, holds otherwise.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      user_rd_data <= '0;
    end else if (user_rden) begin
      user_rd_data <= rd_mux;
    end
  end

  // PWM counter: the >= compare also recovers when the period is shrunk below the running count.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      pwm_cnt <= '0;
    end else if ((pwm_period == '0) || (pwm_cnt >= pwm_period)) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // LED drives: on while the counter is below the lane's duty value.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      led_pwm <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        led_pwm[i] <= (pwm_cnt < duty[i*PWM_W +: PWM_W]);
      end
    end
  end

endmodule

// File: tb/tb_lite_timer_pwm.sv
// Directed bench for lite_timer_pwm: register access, one-shot, auto-reload, collisions, PWM and reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// The DUT never stalls the bus, so every access is a fixed one-cycle step.
module tb_lite_timer_pwm;

  logic        user_clk;
  logic        user_rst;
  logic [31:0] user_addr;
  logic        user_wren;
  logic [3:0]  user_wstrb;
  logic [31:0] user_wr_data;
  logic        user_rden;
  logic [31:0] user_rd_data;
  logic        user_irq;
  logic [3:0]  led_pwm;

  int vectors;
  int miscompares;

  lite_timer_pwm #(.PRESCALE_W(16), .PWM_W(8)) dut (
    .user_clk     (user_clk),
    .user_rst     (user_rst),
    .user_addr    (user_addr),
    .user_wren    (user_wren),
    .user_wstrb   (user_wstrb),
    .user_wr_data (user_wr_data),
    .user_rden    (user_rden),
    .user_rd_data (user_rd_data),
    .user_irq     (user_irq),
    .led_pwm      (led_pwm)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge, one cycle each.
  task automatic wr(input logic [4:0] idx, input logic [31:0] d, input logic [3:0] s);
    user_addr    = {25'd0, idx, 2'b00};
    user_wren    = 1'b1;
    user_wstrb   = s;
    user_wr_data = d;
    @(negedge user_clk);
    user_wren    = 1'b0;
    user_wstrb   = 4'h0;
  endtask

  task automatic rd(input logic [4:0] idx, output logic [31:0] d);
    user_addr = {25'd0, idx, 2'b00};
    user_rden = 1'b1;
    @(negedge user_clk);
    user_rden = 1'b0;
    d = user_rd_data;
  endtask

  logic [31:0] rdat;
  int          ones [4];
  logic [31:0] auto_seq [8];

  initial begin
    vectors      = 0;
    miscompares  = 0;
    user_rst     = 1'b1;
    user_addr    = '0;
    user_wren    = 1'b0;
    user_wstrb   = 4'h0;
    user_wr_data = '0;
    user_rden    = 1'b0;
    repeat (3) @(negedge user_clk);

    // Reset state
    check("rst_rd_data", user_rd_data, 32'h0);
    check("rst_irq", {31'd0, user_irq}, 32'h0);
    check("rst_led", {28'd0, led_pwm}, 32'h0);
    user_rst = 1'b0;

    // Register R/W with byte strobes
    wr(5'd2, 32'hDEADBEEF, 4'b0101);
    rd(5'd2, rdat); check("reload_strb", rdat, 32'h00AD00EF);
    rd(5'd7, rdat); check("id", rdat, 32'h54504D01);
    rd(5'd9, rdat); check("unmapped_9", rdat, 32'h0);
    wr(5'd1, 32'hFFFFFFFF, 4'hF);
    rd(5'd1, rdat); check("prescale_width", rdat, 32'h0000FFFF);

    // One-shot: PRESCALE=3, COUNT=2 -> expiry 8 edges after the CTRL write edge
    wr(5'd1, 32'd3, 4'hF);
    wr(5'd3, 32'd2, 4'hF);
    wr(5'd0, 32'h5, 4'hF);
    repeat (8) @(negedge user_clk);
    check("oneshot_irq_before", {31'd0, user_irq}, 32'h0);
    @(negedge user_clk);
    check("oneshot_irq_rise", {31'd0, user_irq}, 32'h1);
    rd(5'd0, rdat); check("oneshot_ctrl_en_clr", rdat, 32'h4);
    rd(5'd3, rdat); check("oneshot_count", rdat, 32'h0);
    rd(5'd4, rdat); check("oneshot_status", rdat, 32'h1);
    wr(5'd4, 32'h1, 4'h1);
    check("w1c_irq_still", {31'd0, user_irq}, 32'h1);
    @(negedge user_clk);
    check("w1c_irq_fall", {31'd0, user_irq}, 32'h0);
    rd(5'd4, rdat); check("w1c_status", rdat, 32'h0);

    // Auto-reload: PRESCALE=0, RELOAD=4, COUNT=4 -> count 4,3,2,1 then reload
    wr(5'd0, 32'h0, 4'hF);
    wr(5'd1, 32'h0, 4'hF);
    wr(5'd2, 32'd4, 4'hF);
    wr(5'd3, 32'd4, 4'hF);
    wr(5'd0, 32'h3, 4'hF);
    auto_seq = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd4, 32'd3, 32'd2, 32'd1};
    user_addr = {25'd0, 5'd3, 2'b00};
    user_rden = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge user_clk);
      check($sformatf("auto_count_%0d", i), user_rd_data, auto_seq[i]);
    end
    user_rden = 1'b0;
    // Expiries land on edges 4, 8, 12 after the CTRL write; this clear lands on edge 9.
    wr(5'd4, 32'h1, 4'h1);
    rd(5'd4, rdat); check("auto_clear", rdat, 32'h0);
    @(negedge user_clk);
    // This clear lands on edge 12, together with an expiry: set wins.
    wr(5'd4, 32'h1, 4'h1);
    rd(5'd4, rdat); check("w1c_vs_expire", rdat, 32'h1);

    // Same-cycle read and write of RELOAD returns the old value
    user_addr    = {25'd0, 5'd2, 2'b00};
    user_wren    = 1'b1;
    user_wstrb   = 4'hF;
    user_wr_data = 32'h55;
    user_rden    = 1'b1;
    @(negedge user_clk);
    user_wren = 1'b0;
    user_rden = 1'b0;
    check("rd_wr_same_old", user_rd_data, 32'd4);
    rd(5'd2, rdat); check("rd_wr_same_new", rdat, 32'h55);

    // Write/tick collision: write wins over the decrement
    wr(5'd0, 32'h0, 4'hF);
    wr(5'd3, 32'd1000, 4'hF);
    wr(5'd0, 32'h1, 4'hF);
    wr(5'd3, 32'd100, 4'hF);
    rd(5'd3, rdat); check("collision_count", rdat, 32'd100);
    wr(5'd0, 32'h0, 4'hF);

    // PWM: period 9 (10 steps), duties lane0=10, lane1=0, lane2=5, lane3=255
    wr(5'd5, 32'd9, 4'hF);
    wr(5'd6, 32'hFF05000A, 4'hF);
    repeat (3) @(negedge user_clk);
    for (int l = 0; l < 4; l++) ones[l] = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge user_clk);
      for (int l = 0; l < 4; l++) ones[l] += int'(led_pwm[l]);
    end
    check("pwm_lane0_on", 32'(ones[0]), 32'd10);
    check("pwm_lane1_off", 32'(ones[1]), 32'd0);
    check("pwm_lane2_half", 32'(ones[2]), 32'd5);
    check("pwm_lane3_on", 32'(ones[3]), 32'd10);

    // Reset mid-operation with the timer running and user_irq high
    wr(5'd1, 32'h0, 4'hF);
    wr(5'd2, 32'd2, 4'hF);
    wr(5'd3, 32'd2, 4'hF);
    wr(5'd0, 32'h7, 4'hF);
    repeat (4) @(negedge user_clk);
    check("pre_rst_irq", {31'd0, user_irq}, 32'h1);
    rd(5'd7, rdat);
    user_rst = 1'b1;
    @(negedge user_clk);
    check("mid_rst_rd_data", user_rd_data, 32'h0);
    check("mid_rst_irq", {31'd0, user_irq}, 32'h0);
    check("mid_rst_led", {28'd0, led_pwm}, 32'h0);
    user_rst = 1'b0;
    rd(5'd0, rdat); check("post_rst_ctrl", rdat, 32'h0);
    rd(5'd3, rdat); check("post_rst_count", rdat, 32'h0);
    rd(5'd6, rdat); check("post_rst_duty", rdat, 32'h0);
    rd(5'd2, rdat); check("post_rst_reload", rdat, 32'h0);
    check("post_rst_irq", {31'd0, user_irq}, 32'h0);
    check("post_rst_led", {28'd0, led_pwm}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
